// File: rtl/jellyvl_etherneco_pkg.sv
// Framing definitions for the EtherNeco ring, shared by the transmit and receive paths.
// A frame is: type, length-1 (LE 16-bit), payload, 8-bit additive checksum.
package jellyvl_etherneco_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen0,
        StLen1,
        StPayload,
        StCsum,
        StDiscard
    } rx_state_t;

    localparam logic [1:0] ErrNone  = 2'd0;
    localparam logic [1:0] ErrShort = 2'd1;
    localparam logic [1:0] ErrLong  = 2'd2;
    localparam logic [1:0] ErrCsum  = 2'd3;

    localparam int unsigned HeaderLength = 3;

endpackage

// File: rtl/jellyvl_etherneco_packet_rx_if.sv
// Ring receive stream in, payload stream out, plus per-packet status for the parser.
interface jellyvl_etherneco_packet_rx_if;

    logic        s_first;
    logic        s_last;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;

    logic        m_first;
    logic        m_last;
    logic [7:0]  m_data;
    logic        m_valid;

    logic [7:0]  rx_type;
    logic [15:0] rx_length;
    logic        rx_start;
    logic        rx_ok;
    logic        rx_error;
    logic [1:0]  rx_error_code;

    modport slave (
        input  s_first, s_last, s_data, s_valid,
        output s_ready,
        output m_first, m_last, m_data, m_valid,
        output rx_type, rx_length, rx_start, rx_ok, rx_error, rx_error_code
    );

    modport master (
        output s_first, s_last, s_data, s_valid,
        input  s_ready,
        input  m_first, m_last, m_data, m_valid,
        input  rx_type, rx_length, rx_start, rx_ok, rx_error, rx_error_code
    );

endinterface

// File: rtl/jellyvl_etherneco_packet_rx.sv
// EtherNeco ring receive parser: strips header/checksum, forwards payload, reports status.
// Every output is a register; payload leaves one cycle after its input beat.
module jellyvl_etherneco_packet_rx
    import jellyvl_etherneco_pkg::*;
#(
    parameter int unsigned MAX_LENGTH = 16'hffff
) (
    input logic                         reset,
    input logic                         clk,
    jellyvl_etherneco_packet_rx_if.slave bus
);

    rx_state_t   r_state;
    logic        r_ready;
    logic [7:0]  r_sum;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len_m1;
    logic [15:0] r_count;

    logic        r_m_first;
    logic        r_m_last;
    logic [7:0]  r_m_data;
    logic        r_m_valid;
    logic [7:0]  r_rx_type;
    logic [15:0] r_rx_length;
    logic        r_rx_start;
    logic        r_rx_ok;
    logic        r_rx_error;
    logic [1:0]  r_rx_error_code;

    logic        w_accept;
    logic [16:0] w_length;
    logic        w_oversize;
    logic        w_cnt_last;

    assign w_accept   = bus.s_valid & r_ready;
    // 17 bits so a length field of 0xffff does not wrap to zero before the size check
    assign w_length   = {1'b0, bus.s_data, r_len_lo} + 17'd1;
    assign w_oversize = w_length > 17'(MAX_LENGTH);
    assign w_cnt_last = (r_count == r_len_m1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= StIdle;
            r_ready         <= 1'b0;
            r_sum           <= '0;
            r_len_lo        <= '0;
            r_len_m1        <= '0;
            r_count         <= '0;
            r_m_first       <= 1'b0;
            r_m_last        <= 1'b0;
            r_m_data        <= '0;
            r_m_valid       <= 1'b0;
            r_rx_type       <= '0;
            r_rx_length     <= '0;
            r_rx_start      <= 1'b0;
            r_rx_ok         <= 1'b0;
            r_rx_error      <= 1'b0;
            r_rx_error_code <= ErrNone;
        end else begin
            r_ready    <= 1'b1;
            r_m_valid  <= 1'b0;
            r_m_first  <= 1'b0;
            r_m_last   <= 1'b0;
            r_rx_start <= 1'b0;
            r_rx_ok    <= 1'b0;
            r_rx_error <= 1'b0;

            if (w_accept) begin
                if (bus.s_first) begin
                    // A new frame start always wins: it aborts whatever was in flight
                    if (r_state != StIdle || bus.s_last) begin
                        r_rx_error      <= 1'b1;
                        r_rx_error_code <= ErrShort;
                    end
                    if (bus.s_last) begin
                        r_state <= StIdle;
                    end else begin
                        r_rx_type <= bus.s_data;
                        r_sum     <= bus.s_data;
                        r_state   <= StLen0;
                    end
                end else begin
                    case (r_state)
                        StIdle: begin
                        end
                        StLen0: begin
                            r_len_lo <= bus.s_data;
                            r_sum    <= r_sum + bus.s_data;
                            if (bus.s_last) begin
                                r_rx_error      <= 1'b1;
                                r_rx_error_code <= ErrShort;
                                r_state         <= StIdle;
                            end else begin
                                r_state <= StLen1;
                            end
                        end
                        StLen1: begin
                            r_sum <= r_sum + bus.s_data;
                            if (bus.s_last) begin
                                r_rx_error      <= 1'b1;
                                r_rx_error_code <= ErrShort;
                                r_state         <= StIdle;
                            end else if (w_oversize) begin
                                r_rx_error      <= 1'b1;
                                r_rx_error_code <= ErrLong;
                                r_state         <= StDiscard;
                            end else begin
                                r_rx_start      <= 1'b1;
                                r_rx_error_code <= ErrNone;
                                r_rx_length     <= w_length[15:0];
                                r_len_m1        <= {bus.s_data, r_len_lo};
                                r_count         <= '0;
                                r_state         <= StPayload;
                            end
                        end
                        StPayload: begin
                            r_m_valid <= 1'b1;
                            r_m_data  <= bus.s_data;
                            r_m_first <= (r_count == 16'd0);
                            r_m_last  <= w_cnt_last | bus.s_last;
                            r_sum     <= r_sum + bus.s_data;
                            r_count   <= r_count + 16'd1;
                            if (bus.s_last) begin
                                // Frame ended before its checksum byte arrived
                                r_rx_error      <= 1'b1;
                                r_rx_error_code <= ErrShort;
                                r_state         <= StIdle;
                            end else if (w_cnt_last) begin
                                r_state <= StCsum;
                            end
                        end
                        StCsum: begin
                            if (!bus.s_last) begin
                                r_rx_error      <= 1'b1;
                                r_rx_error_code <= ErrLong;
                                r_state         <= StDiscard;
                            end else begin
                                if (bus.s_data == r_sum) begin
                                    r_rx_ok <= 1'b1;
                                end else begin
                                    r_rx_error      <= 1'b1;
                                    r_rx_error_code <= ErrCsum;
                                end
                                r_state <= StIdle;
                            end
                        end
                        StDiscard: begin
                            if (bus.s_last) begin
                                r_state <= StIdle;
                            end
                        end
                        default: r_state <= StIdle;
                    endcase
                end
            end
        end
    end

    assign bus.s_ready       = r_ready;
    assign bus.m_first       = r_m_first;
    assign bus.m_last        = r_m_last;
    assign bus.m_data        = r_m_data;
    assign bus.m_valid       = r_m_valid;
    assign bus.rx_type       = r_rx_type;
    assign bus.rx_length     = r_rx_length;
    assign bus.rx_start      = r_rx_start;
    assign bus.rx_ok         = r_rx_ok;
    assign bus.rx_error      = r_rx_error;
    assign bus.rx_error_code = r_rx_error_code;

endmodule

// File: doc/jellyvl_etherneco_packet_rx.md
# jellyvl_etherneco_packet_rx

Receive-side packet parser for the EtherNeco ring. It consumes the byte stream returning on a ring port (the inner/outer `rx` first/last/data/valid stream). It strips and checks the header and checksum, then forwards payload bytes to the function blocks (synctimer master/slave response handlers). It is the receive counterpart of `jellyvl_etherneco_tx` and reports type, length, start, and completion/error status per packet.

## Interface
Parameters:
- `MAX_LENGTH`, 16'hffff: largest accepted payload byte count. Larger packets are rejected.

Ports:
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `clk` in 1: single clock for all logic.
- `s_first` in 1: first byte of frame.
- `s_last` in 1: last byte of frame.
- `s_data` in 8: frame byte.
- `s_valid` in 1: byte valid.
- `s_ready` out 1: 0 in reset, then constant 1. The block never backpressures.
- `m_first` out 1: first payload byte.
- `m_last` out 1: last payload byte, or the byte on which a truncated packet ended.
- `m_data` out 8: payload byte.
- `m_valid` out 1: payload byte valid. There is no `m_ready`; the sink must accept every byte.
- `rx_type` out 8: type byte of the current/last packet. Held until the next header.
- `rx_length` out 16: payload byte count (length field + 1). Held.
- `rx_start` out 1: one-cycle pulse when the header is complete.
- `rx_ok` out 1: one-cycle pulse when the packet ends with a good checksum.
- `rx_error` out 1: one-cycle pulse when the packet is aborted or corrupt.
- `rx_error_code` out 2: 0 none, 1 short, 2 long/oversize, 3 checksum. Held until the next error or `rx_start`.

## Operation
Frame format: type (1 byte), then length−1 (2 bytes, little-endian), then payload (length bytes), then checksum (1 byte). The checksum is the 8-bit sum of all preceding bytes.

Only beats with `s_valid`=1 are considered. States:
- IDLE
  - `s_first`: latch type, set sum=type, go LEN0.
  - Beats without `s_first` are ignored.
- LEN0: latch the low byte, go LEN1.
- LEN1: latch the high byte and compute length = {hi,lo}+1 in 17 bits.
  - If length > `MAX_LENGTH`: error 2, go DISCARD.
  - Otherwise: `rx_start`, clear the counter, go PAYLOAD.
- PAYLOAD: forward the byte, add it to sum, and increment the counter.
  - `m_first` is set when counter==0.
  - `m_last` is set when counter==length−1; then go CSUM.
- CSUM: compare the byte with sum.
  - Match and `s_last`: `rx_ok`.
  - Mismatch: error 3.
  - No `s_last`: error 2, go DISCARD. Length is checked in preference to checksum.
  - Then go IDLE.
- DISCARD: drop bytes until `s_last`, then go IDLE. No further error pulse.

Boundary rules:
- `s_last` in LEN0 or LEN1: error 1, go IDLE.
- `s_last` in PAYLOAD before the final byte: forward the byte with `m_last`=1, error 1, go IDLE.
- `s_first` in any non-IDLE state: error 1 for the old packet. The byte is treated as a new type byte and the FSM goes to LEN0.
- `s_first` and `s_last` on the same beat in IDLE: error 1, stay IDLE.
- All sums and counters wrap modulo their width. The counter is 16 bits and compares against length−1.

## Timing
- All outputs are registered. Payload appears on `m_*` one cycle after the input beat is accepted.
- `rx_start` fires one cycle after the LEN1 beat.
- `rx_ok` and `rx_error` fire one cycle after the terminating beat. They are mutually exclusive in a given cycle.
- A new packet may start on the beat immediately after the checksum beat; no gap is required.
- Reset (asynchronous assert, synchronous release by the system) returns to IDLE. All outputs go to 0 and held fields are cleared. A packet in flight produces no pulse.

## Structure
- Shared `jellyvl_etherneco_pkg`:
  - FSM state enum (IDLE, LEN0, LEN1, PAYLOAD, CSUM, DISCARD).
  - Error-code constants.
  - Header length constant 3.
  - This package is shared with `jellyvl_etherneco_tx` so the framing definition lives in one place.
- Single module; no sub-module is warranted.

## Test plan
- Good packet: 10 02 00 AA BB CC 43, with `s_last` on 43. Expected: `rx_start`, `rx_type`=0x10, `rx_length`=3. `m_data` is AA/BB/CC with `m_first` on AA and `m_last` on CC. `rx_ok` fires one cycle after 43.
- Bad checksum: same packet with 44. Expected: payload forwarded, `rx_error` with code 3, no `rx_ok`.
- Truncation: `s_last` on BB. Expected: BB has `m_last`=1, `rx_error` code 1. A following good packet back-to-back parses correctly.
- Oversize: `MAX_LENGTH`=4, length field 0x0004. Expected: `rx_error` code 2, no `m_valid`, and the rest is dropped until `s_last`.
- Re-sync: `s_first` mid-payload. Expected: error code 1, then the new header is parsed. Idle stray bytes without `s_first` produce no output.
- Reset: drive `reset` low mid-payload. Expected: all outputs 0 asynchronously. After release, a good packet gives `rx_ok`.
